// File: rtl/npu_v2_array_emulator.sv
// -----------------------------------------------------------------------------
// npu_v2_array_emulator
// Chip-side stand-in for the NPU v2 analog array pins: the far end of the
// wrap's pin interface, used for FPGA loopback and closed-loop simulation.
// All pin inputs are same-domain levels. Strobes are edge-detected against
// their value sampled on the previous clk.
//
// Optional build macro:
//   NPU_EMU_DAC_READBACK_EN - ADC returns dac_mem[ADDR][7:2] instead of ADDR[5:0]
//
// Ports:
//   clk, reset     system clock, asynchronous active-high reset
//   DIN, ADDR      DAC data / DAC-ADC address
//   CLKDAC         DAC write strobe (rising edge writes dac_mem[ADDR])
//   CLKREG         per-ring shift clocks (rising edge shifts ring i)
//   DINSWREG       per-ring serial data
//   CLKADC         ADC convert strobe; DISCHG aborts/releases a conversion
//   SET, RESET     WL / BL ground enables (both high flags err_setreset)
//   DOUT           ADC result, ADC_LATENCY cycles after the CLKADC rise
//   ring_tap       shift-out bit (MSB) of each ring
//   dac_wr_cnt, adc_conv_cnt, adc_abort_cnt   saturating event counters
//   err_setreset   sticky SET&&RESET error flag
// -----------------------------------------------------------------------------
module npu_v2_array_emulator #(
    parameter int unsigned DAC_DEPTH   = 512,
    parameter int unsigned RING_LEN    = 64,
    parameter int unsigned ADC_LATENCY = 3,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       DIN,
    input  logic [8:0]       ADDR,
    input  logic             CLKDAC,
    input  logic [3:0]       CLKREG,
    input  logic [3:0]       DINSWREG,
    input  logic             CLKADC,
    input  logic             DISCHG,
    input  logic             SET,
    input  logic             RESET,
    output logic [5:0]       DOUT,
    output logic [3:0]       ring_tap,
    output logic [CNT_W-1:0] dac_wr_cnt,
    output logic [CNT_W-1:0] adc_conv_cnt,
    output logic [CNT_W-1:0] adc_abort_cnt,
    output logic             err_setreset
);

    localparam int unsigned LAT_W  = 4;
    localparam int unsigned N_RING = 4;
    localparam int unsigned V_W    = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_HOLD = 2'd2
    } adc_state_e;

    adc_state_e              state_q, state_d;
    logic                    clkdac_q, clkadc_q;
    logic [N_RING-1:0]       clkreg_q;
    logic [LAT_W-1:0]        lat_q;
    logic [V_W-1:0]          samp_q;
    logic [RING_LEN-1:0]     ring_q [N_RING];

    logic                    dac_rise, adc_rise, adc_fall;
    logic [N_RING-1:0]       reg_rise;
    logic [V_W-1:0]          sample_c;
    logic                    conv_start_c, conv_done_c, conv_abort_c, hold_rel_c;

    // Strobe edge detection against last sampled level
    assign dac_rise = CLKDAC & ~clkdac_q;
    assign adc_rise = CLKADC & ~clkadc_q;
    assign adc_fall = ~CLKADC & clkadc_q;
    assign reg_rise = CLKREG & ~clkreg_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clkdac_q <= 1'b0;
            clkadc_q <= 1'b0;
            clkreg_q <= '0;
        end else begin
            clkdac_q <= CLKDAC;
            clkadc_q <= CLKADC;
            clkreg_q <= CLKREG;
        end
    end

    // DAC register file (no reset). The ADC sample is taken from the old
    // contents on a same-cycle write, since the write lands at the same edge.
`ifdef NPU_EMU_DAC_READBACK_EN
    logic [7:0] dac_mem [DAC_DEPTH];

    always_ff @(posedge clk) begin
        if (dac_rise) begin
            dac_mem[ADDR] <= DIN;
        end
    end

    assign sample_c = dac_mem[ADDR][7:2];
`else
    // Write-only in this build; nothing reads it, so synthesis may trim it
    logic [7:0] dac_mem_unused [DAC_DEPTH];

    always_ff @(posedge clk) begin
        if (dac_rise) begin
            dac_mem_unused[ADDR] <= DIN;
        end
    end

    assign sample_c = ADDR[V_W-1:0];
`endif

    // Ring switch shift registers, independent per ring
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_RING; i++) begin
                ring_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_RING; i++) begin
                if (reg_rise[i]) begin
                    ring_q[i] <= {ring_q[i][RING_LEN-2:0], DINSWREG[i]};
                end
            end
        end
    end

    // Tap is the MSB flop itself
    always_comb begin
        ring_tap = '0;
        for (int i = 0; i < N_RING; i++) begin
            ring_tap[i] = ring_q[i][RING_LEN-1];
        end
    end

    // ADC FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ADC FSM next state; abort wins over latency expiry in the same cycle
    always_comb begin
        state_d      = state_q;
        conv_start_c = 1'b0;
        conv_done_c  = 1'b0;
        conv_abort_c = 1'b0;
        hold_rel_c   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (adc_rise && !DISCHG) begin
                    state_d      = ST_CONV;
                    conv_start_c = 1'b1;
                end
            end
            ST_CONV: begin
                if (adc_fall || DISCHG) begin
                    state_d      = ST_IDLE;
                    conv_abort_c = 1'b1;
                end else if (lat_q == '0) begin
                    state_d     = ST_HOLD;
                    conv_done_c = 1'b1;
                end
            end
            ST_HOLD: begin
                if (adc_fall || DISCHG) begin
                    state_d    = ST_IDLE;
                    hold_rel_c = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Latency counter, captured sample and DOUT register.
    // Loading LATENCY-1 puts DOUT valid ADC_LATENCY edges after the rise edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_q  <= '0;
            samp_q <= '0;
            DOUT   <= '0;
        end else begin
            if (conv_start_c) begin
                lat_q  <= LAT_W'(ADC_LATENCY - 1);
                samp_q <= sample_c;
            end else if (state_q == ST_CONV && lat_q != '0) begin
                lat_q <= lat_q - LAT_W'(1);
            end

            if (conv_done_c) begin
                DOUT <= samp_q;
            end else if (conv_abort_c || hold_rel_c) begin
                DOUT <= '0;
            end
        end
    end

    // Saturating event counters and sticky SET/RESET error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dac_wr_cnt    <= '0;
            adc_conv_cnt  <= '0;
            adc_abort_cnt <= '0;
            err_setreset  <= 1'b0;
        end else begin
            if (dac_rise && dac_wr_cnt != '1) begin
                dac_wr_cnt <= dac_wr_cnt + CNT_W'(1);
            end
            if (conv_done_c && adc_conv_cnt != '1) begin
                adc_conv_cnt <= adc_conv_cnt + CNT_W'(1);
            end
            if (conv_abort_c && adc_abort_cnt != '1) begin
                adc_abort_cnt <= adc_abort_cnt + CNT_W'(1);
            end
            if (SET && RESET) begin
                err_setreset <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_npu_v2_array_emulator.sv
// Self-checking bench for npu_v2_array_emulator: a timestamp-based reference
// model checked every cycle, plus directed literal expectations.
module tb_npu_v2_array_emulator;

    localparam int unsigned LAT    = 3;
    localparam int unsigned RLEN   = 64;
    localparam int          MAXCNT = 65535;

`ifdef NPU_EMU_DAC_READBACK_EN
    localparam logic [5:0] EXP_107_OLD = 6'h2D;  // 8'hB4 >> 2
    localparam logic [5:0] EXP_107_NEW = 6'h10;  // 8'h40 >> 2
    localparam int         EXP_WR_SAME = 3;
`else
    localparam logic [5:0] EXP_107_OLD = 6'h07;  // ADDR[5:0]
    localparam logic [5:0] EXP_107_NEW = 6'h07;
    localparam int         EXP_WR_SAME = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  DIN = '0;
    logic [8:0]  ADDR = '0;
    logic        CLKDAC = 1'b0;
    logic [3:0]  CLKREG = '0;
    logic [3:0]  DINSWREG = '0;
    logic        CLKADC = 1'b0;
    logic        DISCHG = 1'b0;
    logic        SET = 1'b0;
    logic        RESET = 1'b0;

    logic [5:0]  DOUT;
    logic [3:0]  ring_tap;
    logic [15:0] dac_wr_cnt, adc_conv_cnt, adc_abort_cnt;
    logic        err_setreset;

    logic [5:0]  s_dout;
    logic [3:0]  s_tap;
    logic [7:0]  s_wr, s_conv, s_abort;
    logic        s_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    npu_v2_array_emulator u_dut (
        .clk(clk), .reset(reset), .DIN(DIN), .ADDR(ADDR), .CLKDAC(CLKDAC),
        .CLKREG(CLKREG), .DINSWREG(DINSWREG), .CLKADC(CLKADC), .DISCHG(DISCHG),
        .SET(SET), .RESET(RESET), .DOUT(DOUT), .ring_tap(ring_tap),
        .dac_wr_cnt(dac_wr_cnt), .adc_conv_cnt(adc_conv_cnt),
        .adc_abort_cnt(adc_abort_cnt), .err_setreset(err_setreset)
    );

    // Narrow-counter instance so saturation is reachable in a short run
    npu_v2_array_emulator #(.CNT_W(8)) u_sat (
        .clk(clk), .reset(reset), .DIN(DIN), .ADDR(ADDR), .CLKDAC(CLKDAC),
        .CLKREG(CLKREG), .DINSWREG(DINSWREG), .CLKADC(CLKADC), .DISCHG(DISCHG),
        .SET(SET), .RESET(RESET), .DOUT(s_dout), .ring_tap(s_tap),
        .dac_wr_cnt(s_wr), .adc_conv_cnt(s_conv),
        .adc_abort_cnt(s_abort), .err_setreset(s_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // A conversion is described by its start edge index; it completes at
    // start+LAT unless CLKADC falls or DISCHG is seen at or before that edge.
    logic [7:0]      mem_m [512];
    logic [RLEN-1:0] m_ring [4];
    logic [5:0]      m_dout = '0;
    logic [5:0]      m_val  = '0;
    logic            m_err  = 1'b0;
    logic            m_active = 1'b0;
    int              m_wr = 0, m_conv = 0, m_abort = 0;
    int unsigned     cyc = 0, m_start = 0;
    logic            p_dac = 1'b0, p_adc = 1'b0;
    logic [3:0]      p_reg = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_dout = '0; m_err = 1'b0; m_active = 1'b0;
            m_wr = 0; m_conv = 0; m_abort = 0;
            p_dac = 1'b0; p_adc = 1'b0; p_reg = '0;
            for (int i = 0; i < 4; i++) m_ring[i] = '0;
        end else begin
            cyc++;
            if (m_active) begin
                if ((!CLKADC && p_adc) || DISCHG) begin
                    if (cyc <= m_start + LAT && m_abort < MAXCNT) m_abort++;
                    m_dout   = '0;
                    m_active = 1'b0;
                end else if (cyc == m_start + LAT) begin
                    m_dout = m_val;
                    if (m_conv < MAXCNT) m_conv++;
                end
            end else if (CLKADC && !p_adc && !DISCHG) begin
                m_active = 1'b1;
                m_start  = cyc;
`ifdef NPU_EMU_DAC_READBACK_EN
                m_val = mem_m[ADDR][7:2];
`else
                m_val = ADDR[5:0];
`endif
            end
            if (CLKDAC && !p_dac) begin
                mem_m[ADDR] = DIN;
                if (m_wr < MAXCNT) m_wr++;
            end
            for (int i = 0; i < 4; i++)
                if (CLKREG[i] && !p_reg[i]) m_ring[i] = {m_ring[i][RLEN-2:0], DINSWREG[i]};
            if (SET && RESET) m_err = 1'b1;
            p_dac = CLKDAC; p_adc = CLKADC; p_reg = CLKREG;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        logic [3:0] taps;
        for (int i = 0; i < 4; i++) taps[i] = m_ring[i][RLEN-1];
        check("m_dout",  32'(DOUT),          32'(m_dout));
        check("m_tap",   32'(ring_tap),      32'(taps));
        check("m_wr",    32'(dac_wr_cnt),    32'(m_wr));
        check("m_conv",  32'(adc_conv_cnt),  32'(m_conv));
        check("m_abort", 32'(adc_abort_cnt), 32'(m_abort));
        check("m_err",   32'(err_setreset),  32'(m_err));
    end

    // ---------------- directed stimulus ----------------
    task automatic adc_conv(input logic [8:0] a, output logic [5:0] got);
        ADDR = a; CLKADC = 1'b1;
        step(LAT + 1);
        got = DOUT;
        CLKADC = 1'b0;
        step(1);
    endtask

    initial begin
        logic [5:0] got;
        step(3);
        check("rst_dout",  32'(DOUT), 0);
        check("rst_tap",   32'(ring_tap), 0);
        check("rst_wr",    32'(dac_wr_cnt), 0);
        check("rst_conv",  32'(adc_conv_cnt), 0);
        check("rst_abort", 32'(adc_abort_cnt), 0);
        check("rst_err",   32'(err_setreset), 0);
        reset = 1'b0;
        step(2);

        // DAC write B4 @ 107
        ADDR = 9'h107; DIN = 8'hB4; CLKDAC = 1'b1;
        step(1);
        CLKDAC = 1'b0;
        step(1);
        check("wr_one", 32'(dac_wr_cnt), 1);

        // Convert @107, check exact latency edge
        ADDR = 9'h107; CLKADC = 1'b1;
        step(3);
        check("adc_early", 32'(DOUT), 0);
        step(1);
        check("adc_107", 32'(DOUT), 32'(EXP_107_OLD));
        step(1);
        CLKADC = 1'b0;
        step(1);
        check("adc_release", 32'(DOUT), 0);
        check("conv_one", 32'(adc_conv_cnt), 1);

`ifdef NPU_EMU_DAC_READBACK_EN
        ADDR = 9'h025; DIN = 8'h94; CLKDAC = 1'b1;
        step(1);
        CLKDAC = 1'b0;
        step(1);
`endif
        adc_conv(9'h025, got);
        check("adc_025", 32'(got), 32'h25);
        check("conv_two", 32'(adc_conv_cnt), 2);

        // Abort: CLKADC high only 2 cycles
        ADDR = 9'h025; CLKADC = 1'b1;
        step(2);
        CLKADC = 1'b0;
        step(3);
        check("abort_dout", 32'(DOUT), 0);
        check("abort_cnt", 32'(adc_abort_cnt), 1);
        check("abort_conv", 32'(adc_conv_cnt), 2);

        // DISCHG during HOLD clears DOUT next cycle, not an abort
        ADDR = 9'h025; CLKADC = 1'b1;
        step(4);
        check("hold_dout", 32'(DOUT), 32'h25);
        DISCHG = 1'b1;
        step(1);
        check("dischg_dout", 32'(DOUT), 0);
        DISCHG = 1'b0; CLKADC = 1'b0;
        step(2);
        check("dischg_abort", 32'(adc_abort_cnt), 1);
        check("conv_three", 32'(adc_conv_cnt), 3);

        // Same-cycle write and convert returns pre-write content
        ADDR = 9'h107; DIN = 8'h40; CLKDAC = 1'b1; CLKADC = 1'b1;
        step(1);
        CLKDAC = 1'b0;
        step(3);
        check("rbw_dout", 32'(DOUT), 32'(EXP_107_OLD));
        CLKADC = 1'b0;
        step(1);
        check("rbw_wr", 32'(dac_wr_cnt), EXP_WR_SAME);
        adc_conv(9'h107, got);
        check("adc_107_new", 32'(got), 32'(EXP_107_NEW));
        check("conv_five", 32'(adc_conv_cnt), 5);

        // Ring 2: single 1 shifted through 64 positions
        for (int k = 1; k <= 65; k++) begin
            CLKREG = 4'b0100;
            DINSWREG = (k == 1) ? 4'b0100 : 4'b0000;
            step(1);
            CLKREG = 4'b0000; DINSWREG = 4'b0000;
            if (k == 63) check("ring_63", 32'(ring_tap), 0);
            if (k == 64) check("ring_64", 32'(ring_tap), 32'b0100);
            if (k == 65) check("ring_65", 32'(ring_tap), 0);
            step(1);
        end
        for (int k = 0; k < 3; k++) begin
            CLKREG = 4'hF; DINSWREG = 4'hA;
            step(1);
            CLKREG = 4'h0;
            step(1);
        end

        // Sticky SET/RESET error
        SET = 1'b1; RESET = 1'b1;
        step(1);
        SET = 1'b0; RESET = 1'b0;
        check("err_set", 32'(err_setreset), 1);
        step(3);
        check("err_sticky", 32'(err_setreset), 1);

        // Reset during CONV
        ADDR = 9'h025; CLKADC = 1'b1;
        step(2);
        reset = 1'b1; CLKADC = 1'b0;
        #1;
        check("mid_rst_dout", 32'(DOUT), 0);
        check("mid_rst_conv", 32'(adc_conv_cnt), 0);
        check("mid_rst_abort", 32'(adc_abort_cnt), 0);
        check("mid_rst_err", 32'(err_setreset), 0);
        step(2);
        reset = 1'b0;
        step(5);
        check("post_rst_dout", 32'(DOUT), 0);
        check("post_rst_conv", 32'(adc_conv_cnt), 0);

        // Counter saturation (8-bit instance) vs full-width count
        for (int k = 1; k <= 300; k++) begin
            CLKDAC = 1'b1; DIN = 8'(k); ADDR = 9'(k);
            step(1);
            CLKDAC = 1'b0;
            if (k == 254) check("sat_254", 32'(s_wr), 32'hFE);
            if (k == 255) check("sat_255", 32'(s_wr), 32'hFF);
            step(1);
        end
        check("sat_ff", 32'(s_wr), 32'hFF);
        check("wr_300", 32'(dac_wr_cnt), 300);

        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
